// File: rtl/pipelined_mux_tree.sv
// N:1 select built as a binary tree of registered 2:1 nodes, one register level per tree level.
// The select bits and the valid bit ride down the tree beside the data, and an optional round-robin scan counter can drive the select.

module mux_node #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= sel ? hi : lo;
  end
endmodule

module pipelined_mux_tree #(
  parameter  int WIDTH  = 8,
  parameter  int NCH    = 8,
  localparam int LEVELS = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_bus,
  input  logic                 in_valid,
  input  logic [LEVELS-1:0]    sel_ext,
  input  logic                 scan_en,
  input  logic                 hold,
  output logic [WIDTH-1:0]     out_data,
  output logic [LEVELS-1:0]    out_sel,
  output logic                 out_valid
);
  // Heap layout: node i reduces nodes 2i/2i+1. The leaves are the input channels and node 1 is the root.
  logic [NCH-1:0][WIDTH-1:0]    leaf;
  logic [NCH-1:1][WIDTH-1:0]    tree;
  logic [LEVELS:1][LEVELS-1:0]  sel_pipe;
  logic [LEVELS:1]              vld_pipe;
  logic [LEVELS-1:0]            scan_cnt;
  logic [LEVELS-1:0]            sel_eff;

  assign leaf    = in_bus;
  assign sel_eff = scan_en ? scan_cnt : sel_ext;

  for (genvar i = 1; i < NCH; i++) begin : g_node
    localparam int K = LEVELS - $clog2(i + 1);
    logic [WIDTH-1:0] lo, hi;
    logic             s;
    if (i >= NCH / 2) begin : g_leaf
      assign lo = leaf[2*i-NCH];
      assign hi = leaf[2*i-NCH+1];
    end else begin : g_inner
      assign lo = tree[2*i];
      assign hi = tree[2*i+1];
    end
    // Level 0 selects in the capture cycle; deeper levels use the select carried with their data.
    if (K == 0) begin : g_s0
      assign s = sel_eff[0];
    end else begin : g_sk
      assign s = sel_pipe[K][K];
    end
    mux_node #(.WIDTH(WIDTH)) u_node (
      .clk (clk),
      .rst (rst),
      .en  (~hold),
      .sel (s),
      .lo  (lo),
      .hi  (hi),
      .q   (tree[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_pipe <= '0;
      vld_pipe <= '0;
    end else if (!hold) begin
      sel_pipe[1] <= sel_eff;
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= LEVELS; k++) begin
        sel_pipe[k] <= sel_pipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
    end
  end

  // The counter wraps naturally because NCH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              scan_cnt <= '0;
    else if (!hold && scan_en && in_valid) scan_cnt <= scan_cnt + LEVELS'(1);
  end

  assign out_data  = tree[1];
  assign out_sel   = sel_pipe[LEVELS];
  assign out_valid = vld_pipe[LEVELS];
endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Scoreboard bench: two tree instances (4x8 and 8x16) driven by directed vectors with hand-written expectations.
module tb_pipelined_mux_tree;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  a_bus = 32'hD3C2B1A0;
  logic         a_vld = 1'b0, a_scan = 1'b0;
  logic [1:0]   a_sel_ext = '0;
  logic [7:0]   a_data;
  logic [1:0]   a_sel;
  logic         a_ov;
  logic [15:0]  a_exp_d = '0;
  logic [2:0]   a_exp_s = '0;

  logic [127:0] b_bus = '0;
  logic         b_vld = 1'b0, b_scan = 1'b0;
  logic [2:0]   b_sel_ext = '0;
  logic [15:0]  b_data;
  logic [2:0]   b_sel;
  logic         b_ov;
  logic [15:0]  b_exp_d = '0;
  logic [2:0]   b_exp_s = '0;

  pipelined_mux_tree #(.WIDTH(8), .NCH(4)) u_a (
    .clk(clk), .rst(rst), .in_bus(a_bus), .in_valid(a_vld), .sel_ext(a_sel_ext),
    .scan_en(a_scan), .hold(hold), .out_data(a_data), .out_sel(a_sel), .out_valid(a_ov));

  pipelined_mux_tree #(.WIDTH(16), .NCH(8)) u_b (
    .clk(clk), .rst(rst), .in_bus(b_bus), .in_valid(b_vld), .sel_ext(b_sel_ext),
    .scan_en(b_scan), .hold(hold), .out_data(b_data), .out_sel(b_sel), .out_valid(b_ov));

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
    int          due;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b;
  logic cur_av = 1'b0, cur_bv = 1'b0;
  int   adv = 0, last_adv = 0;
  int   nvec = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Capture side: a sample is accepted on an unheld, out-of-reset edge and is due LEVELS-1 advancing edges later.
  always @(posedge clk) begin
    if (!rst && !hold) begin
      adv++;
      if (a_vld) qa.push_back('{a_exp_d, a_exp_s, adv + 1});
      if (b_vld) qb.push_back('{b_exp_d, b_exp_s, adv + 2});
    end
  end

  // Monitor: expected output state only changes on advancing edges, so a hold must leave the outputs frozen.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      cur_av = 1'b0;
      cur_bv = 1'b0;
      last_adv = adv;
      chk("a_rst_valid", a_ov, 0);
      chk("a_rst_data", a_data, 0);
      chk("a_rst_sel", a_sel, 0);
      chk("b_rst_valid", b_ov, 0);
      chk("b_rst_data", b_data, 0);
    end else begin
      if (adv != last_adv) begin
        last_adv = adv;
        while (qa.size() > 0 && qa[0].due < adv) begin
          chk("a_overdue", 32'(qa[0].due), 32'(adv));
          void'(qa.pop_front());
        end
        cur_av = (qa.size() > 0 && qa[0].due == adv);
        if (cur_av) cur_a = qa.pop_front();
        while (qb.size() > 0 && qb[0].due < adv) begin
          chk("b_overdue", 32'(qb[0].due), 32'(adv));
          void'(qb.pop_front());
        end
        cur_bv = (qb.size() > 0 && qb[0].due == adv);
        if (cur_bv) cur_b = qb.pop_front();
      end
      chk("a_valid", a_ov, cur_av);
      if (cur_av) begin
        chk("a_data", a_data, cur_a.d);
        chk("a_sel", a_sel, cur_a.s);
      end
      chk("b_valid", b_ov, cur_bv);
      if (cur_bv) begin
        chk("b_data", b_data, cur_b.d);
        chk("b_sel", b_sel, cur_b.s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc_a(input logic v, input logic sc, input logic [1:0] se,
                       input logic [15:0] ed, input logic [2:0] es);
    a_vld = v; a_scan = sc; a_sel_ext = se; a_exp_d = ed; a_exp_s = es;
    tick();
  endtask

  task automatic cyc_b(input logic v, input logic [2:0] se,
                       input logic [15:0] ed, input logic [2:0] es);
    b_vld = v; b_sel_ext = se; b_exp_d = ed; b_exp_s = es;
    tick();
  endtask

  task automatic idle(input int n);
    a_vld = 1'b0;
    b_vld = 1'b0;
    repeat (n) tick();
  endtask

  logic [7:0] ach [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  initial begin
    for (int c = 0; c < 8; c++) b_bus[c*16 +: 16] = 16'h1000 + 16'(c);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single external select, one-cycle pulse.
    cyc_a(1, 0, 2, 16'h00C2, 2);
    idle(4);

    // Round-robin scan, six back-to-back samples with wrap.
    for (int i = 0; i < 6; i++) cyc_a(1, 1, 3, {8'h00, ach[i % 4]}, 3'(i % 4));
    idle(3);

    // Streaming channel 3 with a 3-cycle hold mid-stream; each sample carries a distinct value.
    for (int k = 0; k < 6; k++) begin
      a_bus[31:24] = 8'h30 + 8'(k);
      if (k == 3) begin
        a_vld = 1'b1; a_scan = 1'b0; a_sel_ext = 2'd3;
        hold = 1'b1;
        repeat (3) tick();
        hold = 1'b0;
      end
      cyc_a(1, 0, 3, {8'h00, 8'h30 + 8'(k)}, 3);
    end
    idle(3);
    a_bus = 32'hD3C2B1A0;

    // Async reset with two scan samples in flight (counter is at 2 here).
    cyc_a(1, 1, 0, 16'h00C2, 2);
    cyc_a(1, 1, 0, 16'h00D3, 3);
    a_vld = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("a_async_valid", a_ov, 0);
    chk("a_async_data", a_data, 0);
    tick();
    rst = 1'b0;
    idle(4);

    // Counter restarts at 0, holds across an external-select sample and across a hold.
    cyc_a(1, 1, 0, 16'h00A0, 0);
    cyc_a(1, 1, 0, 16'h00B1, 1);
    cyc_a(1, 0, 0, 16'h00A0, 0);
    cyc_a(1, 1, 3, 16'h00C2, 2);
    a_vld = 1'b1; a_scan = 1'b1;
    hold = 1'b1;
    repeat (2) tick();
    hold = 1'b0;
    cyc_a(1, 1, 0, 16'h00D3, 3);
    cyc_a(1, 1, 0, 16'h00A0, 0);
    idle(3);

    // 8-channel sweep with a bubble in the middle.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) cyc_b(0, 3'd7, 16'h0000, 3'd0);
      cyc_b(1, 3'(i), 16'h1000 + 16'(i), 3'(i));
    end
    idle(5);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/pipelined_mux_tree.md
Name: pipelined_mux_tree

Overview:
- Parametrised N:1 multiplexer built as a binary tree of 2:1 stages, with one register level per tree level.
- Generalises the two-level mux-of-muxes to WIDTH-bit data and NCH channels.
- Adds a valid/stall pipeline and an internal round-robin scan mode.
- Sits between a bank of parallel sample sources and a single serial consumer, for example a channel scanner feeding one ADC/UART path.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 8, number of input channels. Must be a power of two, 2 to 64.
- LEVELS, $clog2(NCH), derived local parameter: tree depth, select width and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_bus  input  NCH*WIDTH  packed channel data; channel c occupies bits [c*WIDTH +: WIDTH].
- in_valid  input  1  inputs and select are valid this cycle.
- sel_ext  input  LEVELS  external channel select, used when scan_en=0.
- scan_en  input  1  1 = use the internal round-robin counter as the select.
- hold  input  1  pipeline stall. All registers and the scan counter freeze.
- out_data  output  WIDTH  selected channel data.
- out_sel  output  LEVELS  channel index that produced out_data.
- out_valid  output  1  out_data/out_sel valid.

Behaviour:
- Reset (rst=1, asynchronous):
  - All stage data registers, stage select registers and stage valid bits go to 0.
  - scan_cnt goes to 0.
  - Outputs: out_data=0, out_sel=0, out_valid=0.
  - Deassertion is sampled synchronously; the first capture can occur on the first rising edge with rst=0.
- Effective select: sel_eff = scan_en ? scan_cnt : sel_ext, evaluated combinationally in the capture cycle.
- Tree structure:
  - Level k (k=0..LEVELS-1) reduces 2^(LEVELS-k) entries to 2^(LEVELS-k-1).
  - Level k uses bit k of the select carried with the data (LSB first).
  - Within each pair, bit=0 picks the lower-indexed entry and bit=1 picks the higher-indexed entry.
- Pipeline:
  - Level 0 registers the NCH/2 reduced values, sel_eff and in_valid.
  - Each later level registers its reduced values plus the forwarded select and valid.
  - out_* are the level LEVELS-1 registers.
- Latency: exactly LEVELS cycles, i.e. in_valid sampled at edge T gives out_valid=1 after edge T+LEVELS-1. Throughput is one sample per cycle when hold=0.
- Bubbles: in_valid=0 is captured as a bubble; the data registers still load and valid=0 propagates. out_data is don't-care when out_valid=0; the bench must not check it.
- hold:
  - hold=1 at an edge leaves every pipeline register and scan_cnt unchanged, and in_valid is ignored.
  - hold has priority over in_valid and scan_en.
  - Outputs stay stable for the whole hold period.
- scan_cnt:
  - Increments by 1 at each edge where hold=0, scan_en=1 and in_valid=1.
  - Wraps from NCH-1 to 0.
  - Holds its value when scan_en=0; re-enabling resumes from the held value.
  - The value used for capture is the pre-increment value.
- Simultaneous events:
  - rst overrides everything.
  - hold with in_valid: nothing is captured and the sample is lost, so the source must keep in_valid/data until hold=0.
  - Changing scan_en between samples takes effect on the next capture; samples already in flight keep their carried select.
- Reset mid-operation flushes all in-flight samples. No out_valid pulse appears until LEVELS cycles after the next capture.
- Width rules: pure selection, no arithmetic. out_data is bit-exact with the chosen channel.

Test Plan:
- NCH=4, WIDTH=8, in_bus={8'hD3,8'hC2,8'hB1,8'hA0} (channel 0 = A0), scan_en=0, sel_ext=2, in_valid pulsed one cycle at edge T -> out_valid=1 for one cycle after edge T+1, out_data=8'hC2, out_sel=2; out_valid=0 otherwise.
- Same bus, scan_en=1, in_valid=1 for 6 consecutive cycles -> out_sel sequence 0,1,2,3,0,1 with out_data A0,B1,C2,D3,A0,B1, valid back-to-back starting 2 cycles after the first capture.
- Streaming with sel_ext=3 and hold=1 for 3 cycles mid-stream -> out_data, out_sel and out_valid frozen during the hold; scan_cnt unchanged; no sample duplicated; stream resumes after hold=0.
- scan_en=1 for 2 samples (channels 0,1), then scan_en=0 with sel_ext=0 for 1 sample, then scan_en=1 -> next scan sample is channel 2 (counter held, not reset).
- rst asserted asynchronously between edges while 2 samples are in flight -> out_valid and out_data drop to 0 immediately, scan_cnt=0, and no stale valid appears after release.
- NCH=8, WIDTH=16, channel c = 16'h1000+c, sweep sel_ext 0..7 one per cycle -> out_data = 16'h1000..16'h1007 in order, 3-cycle latency, out_sel matching.
